// File: rtl/rspi_mem_ctrl_pkg.sv
// Shared constants and types for the rspi external memory controller.
package rspi_mem_ctrl_pkg;

  localparam int         FRAME_BITS = 40;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic port_d;
    logic ram;
    logic rd;
  } grant_t;

  // Flash only ever sees reads; writes are RAM-only.
  function automatic logic [7:0] cmd_for(input logic ram, input logic we);
    return (ram && we) ? CMD_WRITE : CMD_READ;
  endfunction

endpackage

// File: rtl/rspi_mem_ctrl_shifter.sv
// SPI mode-0 frame engine: divides clk into SCLK, shifts a 40-bit word out
// MSB first and collects MISO on each SCLK rising edge.
module rspi_mem_ctrl_shifter
  import rspi_mem_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [FRAME_BITS-1:0] i_tx,
  input  logic                  i_miso,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic                  o_done,
  output logic [7:0]            o_rx
);

  localparam int              DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [5:0]      BIT_LAST = 6'(FRAME_BITS - 1);

  logic                  r_active;
  logic                  r_sclk;
  logic                  r_done;
  logic [DW-1:0]         r_div;
  logic [5:0]            r_bit;
  logic [FRAME_BITS-1:0] r_sh;
  logic [7:0]            r_rx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_sclk   <= 1'b0;
      r_done   <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_sh     <= '0;
      r_rx     <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_active <= 1'b1;
        r_sclk   <= 1'b0;
        r_div    <= '0;
        r_bit    <= '0;
        r_sh     <= i_tx;
      end else if (r_active) begin
        if (r_div == DIV_LAST) begin
          r_div <= '0;
          if (!r_sclk) begin
            r_sclk <= 1'b1;
            r_rx   <= {r_rx[6:0], i_miso};
          end else begin
            // MOSI advances on the falling edge so it is stable across the low phase.
            r_sclk <= 1'b0;
            if (r_bit == BIT_LAST) begin
              r_active <= 1'b0;
              r_done   <= 1'b1;
              r_sh     <= '0;
            end else begin
              r_bit <= r_bit + 1'b1;
              r_sh  <= {r_sh[FRAME_BITS-2:0], 1'b0};
            end
          end
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  assign o_sclk = r_sclk;
  assign o_mosi = r_sh[FRAME_BITS-1];
  assign o_done = r_done;
  assign o_rx   = r_rx;

endmodule

// File: rtl/rspi_mem_ctrl.sv
// Round-robin arbiter between fetch (F) and data (D) ports onto the shared
// rspi bus; decodes flash/RAM, drives chip enables and ack pulses.
module rspi_mem_ctrl
  import rspi_mem_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [7:0]        d_wdata,
  output logic              d_ack,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              rspi_clk,
  output logic              rspi_mosi,
  input  logic              rspi_miso,
  output logic              rspi_flash_ce_n,
  output logic              rspi_ram_ce_n
);

  state_e                r_state;
  grant_t                r_gnt;
  logic                  r_last_d;
  logic                  r_f_ack;
  logic                  r_d_ack;
  logic                  r_busy;
  logic                  r_fce_n;
  logic                  r_rce_n;
  logic [7:0]            r_rdata;

  logic                  w_any;
  logic                  w_pick_d;
  logic                  w_we;
  logic                  w_ram;
  logic                  w_flash_wr;
  logic                  w_start;
  logic                  w_done;
  logic [ADDR_W-1:0]     w_addr;
  logic [7:0]            w_rx;
  logic [FRAME_BITS-1:0] w_tx;

  always_comb begin
    w_any      = f_req | d_req;
    // On a tie the port not served last wins; reset leaves F as "last".
    w_pick_d   = d_req & (~f_req | ~r_last_d);
    w_addr     = w_pick_d ? d_addr : f_addr;
    w_we       = w_pick_d & d_we;
    w_ram      = w_addr[ADDR_W-1];
    w_flash_wr = w_we & ~w_ram;
    w_start    = (r_state == S_IDLE) & w_any & ~w_flash_wr;
    w_tx       = {cmd_for(w_ram, w_we), 24'(w_addr), (w_we ? d_wdata : 8'h00)};
  end

  rspi_mem_ctrl_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(w_start),
    .i_tx   (w_tx),
    .i_miso (rspi_miso),
    .o_sclk (rspi_clk),
    .o_mosi (rspi_mosi),
    .o_done (w_done),
    .o_rx   (w_rx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_last_d <= 1'b0;
      r_f_ack  <= 1'b0;
      r_d_ack  <= 1'b0;
      r_busy   <= 1'b0;
      r_fce_n  <= 1'b1;
      r_rce_n  <= 1'b1;
      r_rdata  <= '0;
    end else begin
      r_f_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            // Flash writes are dropped without touching the bus or the round-robin state.
            if (w_flash_wr) begin
              r_d_ack <= 1'b1;
            end else begin
              r_gnt.port_d <= w_pick_d;
              r_gnt.ram    <= w_ram;
              r_gnt.rd     <= ~w_we;
              r_last_d     <= w_pick_d;
              r_busy       <= 1'b1;
              r_fce_n      <= w_ram;
              r_rce_n      <= ~w_ram;
              r_state      <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          if (w_done) begin
            r_fce_n <= 1'b1;
            r_rce_n <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_f_ack <= ~r_gnt.port_d;
          r_d_ack <= r_gnt.port_d;
          if (r_gnt.rd) r_rdata <= w_rx;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign f_ack           = r_f_ack;
  assign d_ack           = r_d_ack;
  assign busy            = r_busy;
  assign rdata           = r_rdata;
  assign rspi_flash_ce_n = r_fce_n;
  assign rspi_ram_ce_n   = r_rce_n;

endmodule

// File: tb/tb_rspi_mem_ctrl.sv
// Scoreboard bench for rspi_mem_ctrl: two instances (CLK_DIV 1 and 3), each
// with a SPI flash/RAM slave model and an ack-driven monitor.
module tb_rspi_mem_ctrl;

  typedef struct {
    int          inst;
    bit          pd;
    bit          rd;
    bit          bus;
    bit          ram;
    logic [39:0] frame;
    logic [7:0]  rdata;
    int          t_req;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic clk   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [7:0] flash_val(input logic [23:0] a);
    return (a == 24'h000123) ? 8'hA5 : (a[7:0] ^ 8'h3C);
  endfunction

  function automatic void push(input int inst, input bit pd, input bit rd, input bit bus, input bit ram,
                               input logic [39:0] fr, input logic [7:0] rdv, input int t);
    exp_t e;
    e.inst = inst; e.pd = pd; e.rd = rd; e.bus = bus; e.ram = ram;
    e.frame = fr; e.rdata = rdv; e.t_req = t;
    sb.push_back(e);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int DIV = (g == 0) ? 1 : 3;

    logic        rst_n = 1'b1;
    logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [15:0] f_addr = '0, d_addr = '0;
    logic [7:0]  d_wdata = '0;
    logic        f_ack, d_ack, busy, sclk, mosi, fce_n, rce_n;
    logic        miso = 1'b0;
    logic [7:0]  rdata;

    rspi_mem_ctrl #(.CLK_DIV(DIV), .ADDR_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
      .rdata(rdata), .busy(busy),
      .rspi_clk(sclk), .rspi_mosi(mosi), .rspi_miso(miso),
      .rspi_flash_ce_n(fce_n), .rspi_ram_ce_n(rce_n)
    );

    // Slave model: flash is a fixed function of address, RAM a sparse array.
    logic [7:0]  mem [logic [23:0]];
    logic [39:0] sh = '0, last_frame = '0;
    logic [7:0]  rd_byte = '0;
    bit          dev_ram = 0, last_ram = 0;
    int          cnt = 0, nframes = 0, nrise = 0;

    initial mem[24'h008020] = 8'h3C;

    always @(posedge sclk or posedge fce_n or posedge rce_n) begin
      if (fce_n && rce_n) begin
        if (cnt != 0) begin last_frame = sh; last_ram = dev_ram; nframes++; end
        cnt = 0; sh = '0;
      end else if (sclk) begin
        if (cnt == 0) dev_ram = !rce_n;
        sh = {sh[38:0], mosi};
        cnt++;
        if (cnt == 32)
          rd_byte = !fce_n ? flash_val(sh[23:0]) : (mem.exists(sh[23:0]) ? mem[sh[23:0]] : 8'h00);
        if (cnt == 40 && !rce_n && sh[39:32] == 8'h02) mem[sh[31:8]] = sh[7:0];
      end
    end
    always @(posedge sclk) nrise++;
    always @(negedge sclk) miso = (cnt >= 32 && cnt < 40) ? rd_byte[39 - cnt] : 1'b0;

    // Monitor
    int   ce_start = 0, gap = 1, run = 0, hmin = 0, hmax = 0, lmin = 0, lmax = 0;
    int   fr_snap = 0, rise_snap = 0;
    bit   prev_lo = 0, prev_s = 0, lo = 0;
    exp_t e;

    always @(negedge clk) begin
      lo = !fce_n || !rce_n;
      if (lo && !prev_lo) begin
        chk("ce_gap", gap >= 1, 1);
        chk("busy_set", busy, 1);
        ce_start = cyc; run = 0; prev_s = 0;
        hmin = 9999; hmax = 0; lmin = 9999; lmax = 0;
      end
      if (lo) begin
        chk("ce_one_low", fce_n ^ rce_n, 1);
        if (sclk == prev_s) run++;
        else begin
          if (prev_s) begin if (run < hmin) hmin = run; if (run > hmax) hmax = run; end
          else        begin if (run < lmin) lmin = run; if (run > lmax) lmax = run; end
          run = 1;
        end
        prev_s = sclk;
        gap = 0;
      end else gap++;
      prev_lo = lo;

      if (f_ack || d_ack) begin
        chk("ack_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("ack_inst", g, e.inst);
          chk("ack_port", d_ack, e.pd);
          chk("ack_single", f_ack & d_ack, 0);
          chk("busy_clr", busy, 0);
          if (e.rd) chk("rdata", rdata, e.rdata);
          if (e.bus) begin
            chk("frame", last_frame, e.frame);
            chk("dev_ram", last_ram, e.ram);
            chk("latency", cyc - ce_start, 80 * DIV + 2);
            chk("sclk_hi_min", hmin, DIV);
            chk("sclk_hi_max", hmax, DIV);
            chk("sclk_lo_min", lmin, DIV);
            chk("sclk_lo_max", lmax, DIV);
          end else begin
            chk("fw_no_frame", nframes - fr_snap, 0);
            chk("fw_no_sclk", nrise - rise_snap, 0);
            chk("fw_latency", cyc - e.t_req, 1);
          end
          fr_snap = nframes; rise_snap = nrise;
        end
      end
    end
  end

  task automatic wait_ack(input int g, input bit pd, input int tmo);
    bit seen = 0;
    for (int i = 0; i < tmo && !seen; i++) begin
      @(negedge clk);
      seen = (g == 0) ? (pd ? u[0].d_ack : u[0].f_ack) : (pd ? u[1].d_ack : u[1].f_ack);
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL ack_timeout inst%0d port_d=%0d: no ack within %0d cycles", g, pd, tmo);
    end
  endtask

  initial begin
    int k;
    #1 u[0].rst_n = 1'b0; u[1].rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {u[0].fce_n, u[0].rce_n, u[0].sclk, u[0].mosi, u[0].busy, u[0].f_ack, u[0].d_ack}, 7'b1100000);
    chk("reset_rdata", u[0].rdata, 8'h00);
    u[0].rst_n = 1'b1; u[1].rst_n = 1'b1;
    @(negedge clk);

    // 1: flash fetch
    push(0, 0, 1, 1, 0, 40'h0300012300, 8'hA5, -1);
    u[0].f_addr = 16'h0123; u[0].f_req = 1'b1;
    wait_ack(0, 0, 200); u[0].f_req = 1'b0;

    // 2: RAM write then read back
    @(negedge clk);
    push(0, 1, 0, 1, 1, 40'h020080105A, 8'h00, -1);
    u[0].d_we = 1'b1; u[0].d_addr = 16'h8010; u[0].d_wdata = 8'h5A; u[0].d_req = 1'b1;
    wait_ack(0, 1, 200); u[0].d_req = 1'b0;
    @(negedge clk);
    push(0, 1, 1, 1, 1, 40'h0300801000, 8'h5A, -1);
    u[0].d_we = 1'b0; u[0].d_req = 1'b1;
    wait_ack(0, 1, 200); u[0].d_req = 1'b0;

    // 3: contention from reset, D wins the first tie
    u[0].rst_n = 1'b0; @(negedge clk); u[0].rst_n = 1'b1; @(negedge clk);
    u[0].f_addr = 16'h0201; u[0].d_addr = 16'h8020; u[0].d_we = 1'b0;
    push(0, 1, 1, 1, 1, 40'h0300802000, 8'h3C, -1);
    push(0, 0, 1, 1, 0, 40'h0300020100, 8'h3D, -1);
    push(0, 1, 1, 1, 1, 40'h0300802000, 8'h3C, -1);
    push(0, 0, 1, 1, 0, 40'h0300020100, 8'h3D, -1);
    u[0].f_req = 1'b1; u[0].d_req = 1'b1;
    fork
      begin wait_ack(0, 1, 400); wait_ack(0, 1, 400); u[0].d_req = 1'b0; end
      begin wait_ack(0, 0, 400); wait_ack(0, 0, 400); u[0].f_req = 1'b0; end
    join

    // 4: flash write is acked locally with no bus activity
    @(negedge clk);
    u[0].d_we = 1'b1; u[0].d_addr = 16'h0040; u[0].d_wdata = 8'h77;
    push(0, 1, 0, 0, 0, 40'h0, 8'h00, cyc);
    u[0].d_req = 1'b1;
    wait_ack(0, 1, 10); u[0].d_req = 1'b0; u[0].d_we = 1'b0;

    // 5: reset around bit 20 of a fetch aborts it, then a fresh fetch works
    @(negedge clk);
    u[0].f_addr = 16'h0300; u[0].f_req = 1'b1;
    k = 0;
    while (u[0].fce_n && k < 10) begin @(negedge clk); k++; end
    chk("t5_ce_low", u[0].fce_n, 0);
    repeat (40) @(negedge clk);
    u[0].rst_n = 1'b0;
    #1;
    chk("t5_abort_ce", {u[0].fce_n, u[0].rce_n}, 2'b11);
    chk("t5_abort_sclk", u[0].sclk, 0);
    chk("t5_abort_busy", u[0].busy, 0);
    u[0].f_req = 1'b0;
    @(negedge clk); u[0].rst_n = 1'b1; @(negedge clk);
    push(0, 0, 1, 1, 0, 40'h0300012300, 8'hA5, -1);
    u[0].f_addr = 16'h0123; u[0].f_req = 1'b1;
    wait_ack(0, 0, 200); u[0].f_req = 1'b0;

    // 6: CLK_DIV=3 RAM read
    @(negedge clk);
    push(1, 1, 1, 1, 1, 40'h0300802000, 8'h3C, -1);
    u[1].d_addr = 16'h8020; u[1].d_we = 1'b0; u[1].d_req = 1'b1;
    wait_ack(1, 1, 400); u[1].d_req = 1'b0;

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
